// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point adder/subtractor:
// FSM state codes, LED patterns and width-agnostic field/pattern helpers.
package fp_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ALIGN = 3'd1;
   localparam state_t ST_ADD   = 3'd2;
   localparam state_t ST_NORM  = 3'd3;
   localparam state_t ST_ROUND = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   localparam logic [3:0] LED_IDLE  = 4'b0000;
   localparam logic [3:0] LED_ALIGN = 4'b0001;
   localparam logic [3:0] LED_ADD   = 4'b0010;
   localparam logic [3:0] LED_NORM  = 4'b0100;
   localparam logic [3:0] LED_ROUND = 4'b0100;
   localparam logic [3:0] LED_DONE  = 4'b1000;

   // Helpers work on a wide word so one set serves every EXP_W/MAN_W pair;
   // callers size-cast the result back to their own width.
   localparam int FP_MAX_W = 64;
   typedef logic [FP_MAX_W-1:0] fp_word_t;

   function automatic fp_word_t fp_ones(input int n);
      return (fp_word_t'(1) << n) - fp_word_t'(1);
   endfunction

   function automatic logic fp_sign_field(input fp_word_t x, input int exp_w, input int man_w);
      return x[exp_w + man_w];
   endfunction

   function automatic fp_word_t fp_exp_field(input fp_word_t x, input int exp_w, input int man_w);
      return (x >> man_w) & fp_ones(exp_w);
   endfunction

   function automatic fp_word_t fp_man_field(input fp_word_t x, input int man_w);
      return x & fp_ones(man_w);
   endfunction

   function automatic fp_word_t fp_inf(input logic sign, input int exp_w, input int man_w);
      return (fp_word_t'(sign) << (exp_w + man_w)) | (fp_ones(exp_w) << man_w);
   endfunction

   // Canonical quiet NaN: positive, exponent all ones, mantissa MSB set.
   function automatic fp_word_t fp_nan(input int exp_w, input int man_w);
      return fp_inf(1'b0, exp_w, man_w) | (fp_word_t'(1) << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [CNT_W-1:0] cnt_o
);

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      cnt_o = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor: byte-loaded operands, fixed
// five-cycle align/add/normalise/round pipeline walked by a small FSM.
module fp_addsub_seq #(
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23,
   parameter int W      = 1 + EXP_W + MAN_W,
   parameter int NBYTES = (W + 7) / 8,
   parameter int BSW    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           opnd_sel,
   input  logic [BSW-1:0] byte_sel,
   input  logic [7:0]     din,
   input  logic           start,
   input  logic           op_sub,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   result,
   output logic           overflow,
   output logic           underflow,
   output logic           invalid,
   output logic           zero,
   output logic [3:0]     leds
);
   import fp_pkg::*;

   localparam int SIG_W = MAN_W + 4;            // hidden, mantissa, G, R, S
   localparam int SUM_W = MAN_W + 5;            // plus carry
   localparam int RND_W = MAN_W + 2;
   localparam int LZC_W = $clog2(SIG_W + 1);
   localparam int EN_W  = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 2;
   localparam logic [EN_W-1:0] EXP_MAX = EN_W'((1 << EXP_W) - 1);

   state_t state_q, state_d;
   logic [W-1:0] opa_q, opb_q, opa_d, opb_d;
   logic         op_sub_q;

   // Operand fields; B's sign is already the effective (post op_sub) sign.
   logic sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   assign sa = fp_sign_field(fp_word_t'(opa_q), EXP_W, MAN_W);
   assign sb = fp_sign_field(fp_word_t'(opb_q), EXP_W, MAN_W) ^ op_sub_q;
   assign ea = EXP_W'(fp_exp_field(fp_word_t'(opa_q), EXP_W, MAN_W));
   assign eb = EXP_W'(fp_exp_field(fp_word_t'(opb_q), EXP_W, MAN_W));
   assign ma = MAN_W'(fp_man_field(fp_word_t'(opa_q), MAN_W));
   assign mb = MAN_W'(fp_man_field(fp_word_t'(opb_q), MAN_W));

   logic             sign_l_d, eff_sub_d, spec_d, spec_inv_d, swap;
   logic             sign_l_q, eff_sub_q, spec_q, spec_inv_q;
   logic [EXP_W-1:0] exp_l_d, exp_l_q, shift_amt;
   logic [SIG_W-1:0] sig_a, sig_b, sig_sm, shifted, lost;
   logic [SIG_W-1:0] sig_l_d, sig_l_q, sig_s_d, sig_s_q;
   logic [W-1:0]     spec_res_d, spec_res_q;
   logic [SUM_W-1:0] sum_d, sum_q;
   logic [LZC_W-1:0] lzc;
   logic [SIG_W-1:0] norm_mant_d, norm_mant_q;
   logic [EN_W-1:0]  norm_exp_d, norm_exp_q, exp_ext, exp_r;
   logic             norm_zero_d, norm_zero_q, norm_uf_d, norm_uf_q;
   logic             rnd_inc;
   logic [RND_W-1:0] rounded;
   logic [MAN_W-1:0] man_r;
   logic [W-1:0]     res_d;
   logic             ovf_d, unf_d, inv_d, zero_d;

   // Next-state sequencing: only IDLE waits, every other state lasts one cycle.
   // NOTE: every combinational output gets a default first so no path leaves
   // a variable unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ALIGN;
         ST_ALIGN: state_d = ST_ADD;
         ST_ADD:   state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Byte writes into the selected operand; indices past the top byte match no bit.
   always_comb begin
      opa_d = opa_q;
      opb_d = opb_q;
      if (load && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         for (int b = 0; b < W; b++) begin
            if (BSW'(b / 8) == byte_sel) begin
               if (opnd_sel) opb_d[b] = din[b % 8];
               else          opa_d[b] = din[b % 8];
            end
         end
      end
   end

   // ALIGN: order by magnitude, right-shift the smaller with sticky, flag specials.
   always_comb begin
      sig_a      = (ea == '0) ? '0 : {1'b1, ma, 3'b000};
      sig_b      = (eb == '0) ? '0 : {1'b1, mb, 3'b000};
      swap       = {eb, (eb == '0) ? '0 : mb} > {ea, (ea == '0) ? '0 : ma};
      sign_l_d   = swap ? sb : sa;
      exp_l_d    = swap ? eb : ea;
      sig_l_d    = swap ? sig_b : sig_a;
      sig_sm     = swap ? sig_a : sig_b;
      shift_amt  = swap ? (eb - ea) : (ea - eb);
      shifted    = sig_sm >> shift_amt;
      lost       = sig_sm & ~({SIG_W{1'b1}} << shift_amt);
      sig_s_d    = {shifted[SIG_W-1:1], shifted[0] | (|lost)};
      eff_sub_d  = sa ^ sb;
      spec_d     = (ea == '1) || (eb == '1);
      spec_inv_d = (ea == '1) && (eb == '1) && (sa != sb);
      if (spec_inv_d)     spec_res_d = W'(fp_nan(EXP_W, MAN_W));
      else if (ea == '1)  spec_res_d = W'(fp_inf(sa, EXP_W, MAN_W));
      else                spec_res_d = W'(fp_inf(sb, EXP_W, MAN_W));
   end

   // ADD: magnitude sum or larger-minus-smaller difference.
   always_comb begin
      sum_d = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                        : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
   end

   fp_lzc #(.WIDTH(SIG_W), .CNT_W(LZC_W)) u_lzc (
      .in_i  (sum_q[SIG_W-1:0]),
      .cnt_o (lzc)
   );

   // NORM: fold a carry back in, or left-justify; detect zero and flush-to-zero.
   always_comb begin
      norm_mant_d = '0;
      norm_exp_d  = '0;
      norm_zero_d = 1'b0;
      norm_uf_d   = 1'b0;
      exp_ext     = EN_W'(exp_l_q);
      if (sum_q[SUM_W-1]) begin
         norm_mant_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
         norm_exp_d  = exp_ext + EN_W'(1);
      end else if (sum_q == '0) begin
         norm_zero_d = 1'b1;
      end else begin
         norm_mant_d = sum_q[SIG_W-1:0] << lzc;
         norm_exp_d  = exp_ext - EN_W'(lzc);
         if (norm_exp_d[EN_W-1] || norm_exp_d == '0) begin
            norm_zero_d = 1'b1;
            norm_uf_d   = 1'b1;
         end
      end
   end

   // ROUND: nearest-even on G and R|S, renormalise, then pick the final result.
   always_comb begin
      rnd_inc = norm_mant_q[2] & (norm_mant_q[1] | norm_mant_q[0] | norm_mant_q[3]);
      rounded = {1'b0, norm_mant_q[SIG_W-1:3]} + RND_W'(rnd_inc);
      if (rounded[RND_W-1]) begin
         man_r = rounded[MAN_W:1];
         exp_r = norm_exp_q + EN_W'(1);
      end else begin
         man_r = rounded[MAN_W-1:0];
         exp_r = norm_exp_q;
      end
      res_d  = {sign_l_q, exp_r[EXP_W-1:0], man_r};
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      inv_d  = 1'b0;
      zero_d = 1'b0;
      if (spec_q) begin
         res_d = spec_res_q;
         inv_d = spec_inv_q;
      end else if (norm_zero_q) begin
         // Exact cancellation gives +0; a flushed underflow keeps its sign.
         res_d  = {norm_uf_q & sign_l_q, {(W-1){1'b0}}};
         zero_d = 1'b1;
         unf_d  = norm_uf_q;
      end else if (exp_r >= EXP_MAX) begin
         res_d = W'(fp_inf(sign_l_q, EXP_W, MAN_W));
         ovf_d = 1'b1;
      end
   end

   // Architectural state: FSM, operands, sampled op and the held result/flags.
   // NOTE: sequential blocks use non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         op_sub_q  <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
         zero      <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         if (state_q == ST_IDLE && start) op_sub_q <= op_sub;
         if (state_q == ST_ROUND) begin
            result    <= res_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            invalid   <= inv_d;
            zero      <= zero_d;
         end
      end
   end

   // Pipeline stage registers, each loaded in its own state.
   // NOTE: these carry no reset; each is always written in an earlier state
   // before it is read, so reset would only add fan-out.
   always_ff @(posedge clk) begin
      if (state_q == ST_ALIGN) begin
         sign_l_q   <= sign_l_d;
         eff_sub_q  <= eff_sub_d;
         exp_l_q    <= exp_l_d;
         sig_l_q    <= sig_l_d;
         sig_s_q    <= sig_s_d;
         spec_q     <= spec_d;
         spec_inv_q <= spec_inv_d;
         spec_res_q <= spec_res_d;
      end
      if (state_q == ST_ADD) sum_q <= sum_d;
      if (state_q == ST_NORM) begin
         norm_mant_q <= norm_mant_d;
         norm_exp_q  <= norm_exp_d;
         norm_zero_q <= norm_zero_d;
         norm_uf_q   <= norm_uf_d;
      end
   end

   assign busy = (state_q == ST_ALIGN) || (state_q == ST_ADD) ||
                 (state_q == ST_NORM)  || (state_q == ST_ROUND);
   assign done = (state_q == ST_DONE);

   // One-hot state display.
   always_comb begin
      case (state_q)
         ST_ALIGN: leds = LED_ALIGN;
         ST_ADD:   leds = LED_ADD;
         ST_NORM:  leds = LED_NORM;
         ST_ROUND: leds = LED_ROUND;
         ST_DONE:  leds = LED_DONE;
         default:  leds = LED_IDLE;
      endcase
   end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Parametrised sequential floating-point adder/subtractor for IEEE-754-style operands of configurable exponent and mantissa width.
- Operands are loaded byte-wise from the board switch bus into two operand registers.
- A start/busy/done handshake runs a fixed-latency FSM: align, add, normalise, round to nearest even.
- Result and status flags are held for the 7-segment/LED display path.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa width, hidden bit excluded (>=4)
W, 1+EXP_W+MAN_W, derived operand/result width
NBYTES, ceil(W/8), derived byte count for loading

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle byte write strobe
opnd_sel  in  1  0 = operand A, 1 = operand B
byte_sel  in  max(1,$clog2(NBYTES))  byte index, 0 = LSB
din  in  8  byte data
start  in  1  start operation (sampled in IDLE only)
op_sub  in  1  0 = A+B, 1 = A-B (sampled with start)
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
result  out  W  packed sign/exp/mantissa result
overflow  out  1  result saturated to infinity
underflow  out  1  nonzero result flushed to zero
invalid  out  1  Inf-Inf, canonical NaN returned
zero  out  1  result is zero
leds  out  4  one-hot state display

Behaviour:
- Reset (sync, active-high; overrides everything, including mid-operation):
  - operand registers, result, and all flags = 0; busy = 0; done = 0; leds = 0000; state = IDLE.
  - An operation in flight is abandoned with no done pulse.
- Loading:
  - load is honoured only in IDLE or DONE, otherwise ignored.
  - The write replaces byte byte_sel of the selected operand; other bytes are unchanged.
  - Bits beyond W in the top byte are discarded; byte_sel >= NBYTES is ignored.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE, one cycle per state except IDLE.
  - start accepted in IDLE at cycle 0: ALIGN at 1, ADD at 2, NORM at 3, ROUND at 4, DONE at 5.
  - done = 1 and new result/flags visible in cycle 5 only; busy = 1 in cycles 1-4.
  - start outside IDLE is ignored; start held high restarts in the cycle after DONE.
- leds: ALIGN 0001, ADD 0010, NORM 0100, ROUND 0100, DONE 1000, IDLE 0000.
- Special operands:
  - exp = 0 is treated as zero (no subnormals).
  - exp = all-ones is treated as infinity; mantissa is ignored.
  - Inf +/- finite -> that Inf. Same-sign effective Inf add -> Inf.
  - Inf - Inf (effective) -> NaN = sign 0, exp all-ones, mantissa MSB 1; invalid = 1.
  - Specials bypass arithmetic but keep the same 5-cycle latency.
- ALIGN:
  - effective sign of B = signB ^ op_sub.
  - Swap so |A| >= |B|, comparing exponent then mantissa.
  - Significands = {1, mantissa, G, R, S}.
  - Shift the smaller right by d = expA - expB; shifted-out bits OR into S.
  - d >= MAN_W+3: smaller becomes sticky only.
- ADD: magnitude add if signs are equal, else subtract larger minus smaller; width MAN_W+5 including carry.
- NORM:
  - Carry out: shift right 1 (LSB ORed into S), exponent +1.
  - Otherwise: left shift by leading-zero count, exponent -= lzc.
  - Exact zero: result +0, zero = 1.
  - Exponent <= 0 after shift: result signed 0, underflow = 1, zero = 1.
- ROUND:
  - Round to nearest, ties to even, on G and (R|S).
  - Mantissa overflow from rounding renormalises with exponent +1.
  - Exponent >= all-ones after NORM/ROUND: result = signed Inf, overflow = 1.
- Result sign = sign of the larger-magnitude operand.
- Flags and result hold until the next DONE or reset.

Decomposition:
- Package fp_pkg:
  - state enum (IDLE, ALIGN, ADD, NORM, ROUND, DONE)
  - led encoding constants
  - helper functions for field extraction and the canonical NaN/Inf patterns, parametrised by EXP_W/MAN_W
- One sub-module fp_lzc: parametrised combinational leading-zero counter used in NORM.

Test Plan:
- Add: load A = 0x3FC00000 (1.5), B = 0x40200000 (2.5), op_sub = 0, start -> done in cycle 5, result 0x40800000, all flags 0, busy high cycles 1-4.
- Cancellation: A = 0x3F800000, B = 0x3F800000, op_sub = 1 -> result 0x00000000, zero = 1.
- Rounding ties:
  - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even).
  - 0x3F800000 + 0x33800001 -> 0x3F800001.
  - 0x4B800000 + 0x3F800000 -> 0x4B800000.
- Overflow/invalid:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow = 1.
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid = 1.
- Control:
  - load or start during ADD is ignored (operands and result unchanged).
  - reset asserted in ADD -> next cycle busy = 0, done = 0, result = 0, leds = 0000, and no done pulse follows.
- Half precision (EXP_W = 5, MAN_W = 10, NBYTES = 2):
  - 0x3C00 + 0x3C00 -> 0x4000.
  - 0x7BFF + 0x7BFF -> 0x7C00 with overflow = 1.
